// File: rtl/instr_sequencer.sv
// Program RAM plus issue FSM that feeds the lab6 cpu one instruction at a time, pacing on cpu `w`.
// Build option SEQ_SINGLE_STEP_EN adds a `step` input and a HOLD state between instructions.
module instr_sequencer #(
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              cpu_w,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [15:0]       cpu_in,
   output logic              cpu_load,
   output logic              cpu_s,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        dbg_state
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
   localparam logic [7:0]      TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GO    = 3'd2,
      S_WDROP = 3'd3,
      S_WRISE = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
      , S_HOLD = 3'd7
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [15:0]       cpu_in_q, cpu_in_d;
   logic              load_q, load_d;
   logic              s_q, s_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       mem [DEPTH];
   logic              we_ok;
   logic              last_instr;

   assign we_ok      = prog_we && (state_q == S_IDLE);
   assign last_instr = (({1'b0, pc_q} + ONE_L) == len_q);

   always_ff @(posedge clk) begin
      if (we_ok) mem[prog_addr] <= prog_data;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      cpu_in_d = cpu_in_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d = 1'b0;
               if (prog_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                  pc_d    = '0;
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: state_d = S_GO;
         S_GO: begin
            cnt_d   = '0;
            state_d = S_WDROP;
         end
         S_WDROP: begin
            if (!cpu_w) begin
               cnt_d   = '0;
               state_d = S_WRISE;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WRISE: begin
            if (cpu_w) begin
               if (last_instr) begin
                  state_d = S_DONE;
               end else begin
`ifdef SEQ_SINGLE_STEP_EN
                  state_d = S_HOLD;
`else
                  pc_d    = pc_q + 1'b1;
                  state_d = S_LOAD;
`endif
               end
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`ifdef SEQ_SINGLE_STEP_EN
         S_HOLD: begin
            if (step) begin
               pc_d    = pc_q + 1'b1;
               state_d = S_LOAD;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
      // Forward a same-cycle RAM write so the first LOAD sees the new word.
      if (state_d == S_LOAD) begin
         cpu_in_d = (we_ok && (prog_addr == pc_d)) ? prog_data : mem[pc_d];
      end
   end

   assign load_d = (state_d == S_LOAD);
   assign s_d    = (state_d == S_GO);
   assign busy_d = (state_d != S_IDLE);
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         cpu_in_q <= '0;
         load_q   <= 1'b0;
         s_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         // A reset out of the error trap keeps the flag so the cause stays visible.
         err_q    <= (state_q == S_ERR) ? err_q : 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         cpu_in_q <= cpu_in_d;
         load_q   <= load_d;
         s_q      <= s_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign cpu_in    = cpu_in_q;
   assign cpu_load  = load_q;
   assign cpu_s     = s_q;
   assign pc        = pc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: small behavioural cpu stub, load/done scoreboard, directed runs.
module tb_instr_sequencer;

   localparam int ADDR_W  = 4;
   localparam int TIMEOUT = 64;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WDROP = 3'd3;
   localparam logic [2:0] ST_WRISE = 3'd4;
   localparam logic [2:0] ST_ERR   = 3'd6;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              prog_we = 1'b0;
   logic [ADDR_W-1:0] prog_addr = '0;
   logic [15:0]       prog_data = '0;
   logic [ADDR_W:0]   prog_len = '0;
   logic              start = 1'b0;
   logic              cpu_w;
   logic [15:0]       cpu_in;
   logic              cpu_load, cpu_s, busy, done, err;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   int n_load = 0, n_s = 0, n_busy = 0, n_done = 0;
   logic [15:0] exp_load_q[$];
   logic [3:0]  exp_done_q[$];
   logic [15:0] tb_mem [16];
   logic [3:0]  exp_pc = '0;

   always #5 clk = ~clk;

   instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start), .cpu_w(cpu_w),
      .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .pc(pc), .busy(busy),
      .done(done), .err(err), .dbg_state(dbg_state)
   );

   // Behavioural cpu: MOV Rn,#imm8 and ADD Rd,Rn,Rm{sh}; w drops on s, rises after 2 cycles.
   logic [15:0] regs [8] = '{default: 16'h0000};
   logic [15:0] ir = 16'h0000;
   logic        cw_q = 1'b1;
   logic        stuck = 1'b0;
   int          exec_cnt = 0;
   assign cpu_w = stuck ? 1'b1 : cw_q;

   function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
      case (sh)
         2'b01:   return {v[14:0], 1'b0};
         2'b10:   return {1'b0, v[15:1]};
         2'b11:   return {v[15], v[15:1]};
         default: return v;
      endcase
   endfunction

   always @(posedge clk) begin
      if (cpu_load) ir <= cpu_in;
      if (cw_q && cpu_s && !stuck) begin
         cw_q     <= 1'b0;
         exec_cnt <= 2;
      end else if (!cw_q) begin
         if (exec_cnt <= 1) begin
            cw_q <= 1'b1;
            if (ir[15:11] == 5'b11010) regs[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
            else if (ir[15:11] == 5'b10100)
               regs[ir[7:5]] <= regs[ir[10:8]] + shf(regs[ir[2:0]], ir[4:3]);
         end else begin
            exec_cnt <= exec_cnt - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every load and every done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (cpu_load) begin
         n_load++;
         if (exp_load_q.size() == 0) chk("load_unexpected", {16'h0, cpu_in}, 32'hDEAD_BEEF);
         else chk("cpu_in_at_load", {16'h0, cpu_in}, {16'h0, exp_load_q.pop_front()});
      end
      if (cpu_s) n_s++;
      if (busy) n_busy++;
      if (done) begin
         n_done++;
         if (exp_done_q.size() == 0) chk("done_unexpected", 32'h1, 32'h0);
         else chk("pc_at_done", {28'h0, pc}, {28'h0, exp_done_q.pop_front()});
      end
   end

   task automatic clr_counts();
      n_load = 0; n_s = 0; n_busy = 0; n_done = 0;
   endtask

   task automatic write_word(input int a, input logic [15:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_data = d;
      tb_mem[a] = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic push_run(input int len);
      int n;
      n = (len > 16) ? 16 : len;
      for (int i = 0; i < n; i++) exp_load_q.push_back(tb_mem[i]);
      if (n > 0) exp_pc = 4'(n - 1);
      exp_done_q.push_back(exp_pc);
   endtask

   task automatic start_run(input int len);
      @(negedge clk);
      start = 1'b1; prog_len = (ADDR_W+1)'(len);
      push_run(len);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while (busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk({nm, "_idle_timeout"}, 32'h1, 32'h0);
   endtask

   initial begin
      int t, n;
      // 1: reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_load", {31'h0, cpu_load}, 32'h0);
      chk("rst_s", {31'h0, cpu_s}, 32'h0);
      chk("rst_pc", {28'h0, pc}, 32'h0);
      chk("rst_cpu_in", {16'h0, cpu_in}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", {31'h0, busy}, 32'h0);
      chk("post_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});

      // 2: three-instruction program
      write_word(0, 16'hD007);
      write_word(1, 16'hD102);
      write_word(2, 16'hA148);
      clr_counts();
      start_run(3);
      wait_idle("run3");
      repeat (2) @(negedge clk);
      chk("r0", {16'h0, regs[0]}, 32'h0007);
      chk("r1", {16'h0, regs[1]}, 32'h0002);
      chk("r2", {16'h0, regs[2]}, 32'h0010);
      chk("run3_loads", n_load, 3);
      chk("run3_s", n_s, 3);
      chk("run3_dones", n_done, 1);
      chk("run3_pc", {28'h0, pc}, 32'h2);

      // 3: zero-length run
      clr_counts();
      start_run(0);
      wait_idle("run0");
      @(negedge clk);
      chk("run0_loads", n_load, 0);
      chk("run0_busy_cycles", n_busy, 1);
      chk("run0_dones", n_done, 1);

      // 4: cpu never drops w -> timeout trap
      stuck = 1'b1;
      clr_counts();
      start_run(1);
      t = 0;
      while (dbg_state != ST_WDROP && t < 20) begin @(negedge clk); t++; end
      chk("reach_wdrop", {29'h0, dbg_state}, {29'h0, ST_WDROP});
      n = 0;
      while (!err && n < 200) begin @(negedge clk); n++; end
      chk("timeout_cycles", n, TIMEOUT);
      chk("err_state", {29'h0, dbg_state}, {29'h0, ST_ERR});
      chk("err_busy", {31'h0, busy}, 32'h1);
      @(negedge clk); start = 1'b1; prog_len = 5'd1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("err_start_ignored", {29'h0, dbg_state}, {29'h0, ST_ERR});
      chk("err_no_reload", n_load, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("err_kept_by_reset", {31'h0, err}, 32'h1);
      chk("err_reset_busy", {31'h0, busy}, 32'h0);
      chk("leftover_done", exp_done_q.size(), 1);
      exp_done_q.delete();
      exp_pc = '0;
      stuck = 1'b0;
      start_run(1);
      chk("err_cleared_on_start", {31'h0, err}, 32'h0);
      wait_idle("run1");

      // 5: reset during WRISE of instruction 1
      start_run(3);
      t = 0;
      while (!(dbg_state == ST_WRISE && pc == 4'd1) && t < 200) begin @(negedge clk); t++; end
      chk("reach_wrise1", {29'h0, dbg_state}, {29'h0, ST_WRISE});
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_cpu_in", {16'h0, cpu_in}, 32'h0);
      chk("abort_pc", {28'h0, pc}, 32'h0);
      chk("leftover_loads", exp_load_q.size(), 1);
      exp_load_q.delete();
      exp_done_q.delete();
      exp_pc = '0;
      t = 0;
      while (!cpu_w && t < 50) begin @(negedge clk); t++; end

      // 6: rerun with a write attempt while busy (must be ignored)
      clr_counts();
      start_run(3);
      prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hFFFF;
      repeat (2) @(negedge clk);
      prog_we = 1'b0;
      wait_idle("rerun");
      repeat (2) @(negedge clk);
      chk("rerun_r2", {16'h0, regs[2]}, 32'h0010);
      chk("rerun_loads", n_load, 3);

      // write and start in the same cycle: first LOAD sees the new word
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'hD005; tb_mem[0] = 16'hD005;
      start = 1'b1; prog_len = 5'd1;
      push_run(1);
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      wait_idle("wr_start");
      repeat (2) @(negedge clk);
      chk("wr_start_r0", {16'h0, regs[0]}, 32'h0005);

      // length above depth clamps to 16 instructions
      for (int i = 0; i < 16; i++) write_word(i, {5'b11010, 3'(i % 8), 8'(i + 16)});
      clr_counts();
      start_run(20);
      wait_idle("clamp");
      repeat (2) @(negedge clk);
      chk("clamp_loads", n_load, 16);
      chk("clamp_pc", {28'h0, pc}, 32'hF);
      chk("clamp_r7", {16'h0, regs[7]}, 32'h001F);
      chk("sb_empty", exp_load_q.size() + exp_done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
